neuron_mac: RTL and testbench
=============================

# neuron_mac

Multiply-accumulate stage for one NAR-Net neuron. It streams N_IN signed Q1.6 input/weight pairs through a valid/ready handshake and adds a Q1.6 bias. It rescales, saturates and registers the sum as the 8-bit address driven into `tanh_lut`, the stage directly downstream. One result is produced per `start`; `addr` holds between results so the LUT's negedge read always sees a stable value.

## Interface
- `N_IN`, default 4: number of input/weight pairs accumulated per result, range 1..16.
- `ACC_W`, default 24: accumulator width in bits. Must be ≥ 16 + clog2(N_IN) + 2.

- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `start`: input, 1 bit. Begins a result; sampled only in IDLE.
- `bias`: input, 8 bits. Signed Q1.6 bias, latched when `start` is accepted.
- `in_valid`: input, 1 bit. `x_in`/`w_in` beat valid.
- `in_ready`: output, 1 bit. Block accepts a beat.
- `x_in`: input, 8 bits. Signed Q1.6 activation.
- `w_in`: input, 8 bits. Signed Q1.6 weight.
- `addr`: output, 8 bits. Signed Q1.6 saturated sum, fed to `tanh_lut.addr`.
- `addr_valid`: output, 1 bit. One-cycle pulse when `addr` is updated.
- `busy`: output, 1 bit. High in any state other than IDLE.

## Operation
- **States:** IDLE, ACCUM, FINISH.
- **IDLE:** `in_ready`=0, `busy`=0.
  - `start`=1 loads the accumulator with sign-extended `bias` << 6, clears the beat counter, and moves to ACCUM.
- **ACCUM:** `in_ready`=1.
  - A beat transfers when `in_valid` && `in_ready`: acc += x_in × w_in (signed 16-bit Q2.12 product, sign-extended to ACC_W), and the counter increments.
  - On the transfer of beat N_IN, the next state is FINISH.
  - `in_valid`=0 holds state and acc unchanged. Gaps of any length are legal.
- **FINISH:** `in_ready`=0.
  - scaled = acc >>> 6 (arithmetic); rounding follows Configuration.
  - Saturate to [-128, +127] and register into `addr`.
  - Assert `addr_valid` and return to IDLE.
- **Boundary rules:**
  - `start` in ACCUM/FINISH is ignored, with no restart.
  - `start` and `in_valid` high in the same IDLE cycle: no beat is accepted that cycle.
  - `start` in the cycle after FINISH (back in IDLE) is accepted normally, giving back-to-back results.
  - `bias` changes after `start` acceptance have no effect.
  - `x_in`=`w_in`=-128 gives a product of +16384, which is legal; there is no overflow inside ACC_W.
- **Reset:**
  - `rst` asserts asynchronously at any time, including mid-ACCUM.
  - Effect: state=IDLE, acc=0, counter=0, `addr`=0, `addr_valid`=0, `in_ready`=0, `busy`=0.
  - Partial sums are discarded.

## Timing
- Beat throughput: 1 per cycle while `in_valid` is held high.
- Latency from `start` acceptance to `addr_valid` is N_IN + 1 cycles with no gaps. Last beat accepted at edge k → `addr`/`addr_valid` update at edge k+1.
- `addr` changes only at a FINISH edge. `tanh_lut` samples it at the following falling edge, so tanh is valid half a cycle after `addr_valid` rises.
- `addr_valid` is high for exactly one cycle per result.
- Minimum period between results is N_IN + 2 cycles.

## Configuration
- `NEURON_MAC_ROUND_EN` defined: round-half-up before the shift, scaled = (acc + 32) >>> 6, then saturate.
- Macro undefined: truncation toward −∞, scaled = acc >>> 6.
- No other behaviour differs between the two builds.

## Structure
- Package `nar_pkg` holds:
  - `DATA_W`=8 and `FRAC_BITS`=6.
  - Q1.6 saturation limits `Q_MAX`=8'sh7F and `Q_MIN`=8'sh80.
  - The state enum `mac_state_t` (IDLE, ACCUM, FINISH).
- Sub-module `q_round_sat`: purely combinational. Takes the ACC_W-bit acc and returns 8-bit rounded/saturated Q1.6. It contains the `NEURON_MAC_ROUND_EN` switch.

## Test plan
All scenarios use N_IN=4.
- **Basic sum:** bias=0x10; four beats x=0x40, w=0x10 → `addr`=0x50, `addr_valid` pulses one cycle, 5 cycles after `start`.
- **Positive saturation:** bias=0x7F; four beats x=0x7F, w=0x7F → `addr`=0x7F.
- **Negative saturation:** bias=0x00; four beats x=0x80, w=0x7F → `addr`=0x80.
- **Rounding:** bias=0; beats (0x01,0x20), then three beats (0x00,0x00) → `addr`=0x01 with `NEURON_MAC_ROUND_EN` defined, 0x00 without.
- **Backpressure and ignored start:** same stimulus as basic sum, but `in_valid` low for 3 cycles between beats 2 and 3, and `start` pulsed during ACCUM → `addr`=0x50, a single `addr_valid` pulse, no restart.
- **Reset mid-operation:** assert `rst` after beat 2 → all outputs 0 immediately (asynchronous). A fresh `start` with the basic-sum stimulus then yields 0x50.

Source files
------------

// File: rtl/nar_pkg.sv
// Shared NAR-Net definitions: Q1.6 data format, saturation limits and the
// MAC controller state encoding.
package nar_pkg;

    // Q1.6 signed data: 8 bits total, 6 fractional bits
    localparam int DATA_W    = 8;
    localparam int FRAC_BITS = 6;

    // Q1.6 saturation limits (+127/64 and -2.0)
    localparam logic signed [DATA_W-1:0] Q_MAX = 8'sh7F;
    localparam logic signed [DATA_W-1:0] Q_MIN = 8'sh80;

    // MAC controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FINISH = 2'd2
    } mac_state_t;

endpackage

// File: rtl/q_round_sat.sv
// Converts the Q*.12 accumulator of neuron_mac back to 8-bit Q1.6.
// Build option: NEURON_MAC_ROUND_EN selects round-half-up before the shift;
// without it the shift truncates toward minus infinity.
module q_round_sat
    import nar_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0]  i_acc,
    output logic [DATA_W-1:0] o_q
);

    // One guard bit so adding the half-LSB can never wrap
    logic signed [ACC_W:0] w_acc_ext;
    logic signed [ACC_W:0] w_biased;
    logic signed [ACC_W:0] w_scaled;
    logic signed [ACC_W:0] w_max;
    logic signed [ACC_W:0] w_min;

    // Sign-extended Q1.6 limits for comparison at full accumulator width
    assign w_max = {{(ACC_W+1-DATA_W){Q_MAX[DATA_W-1]}}, Q_MAX};
    assign w_min = {{(ACC_W+1-DATA_W){Q_MIN[DATA_W-1]}}, Q_MIN};

    // Optional rounding offset, then arithmetic shift down to Q1.6 scale
    always_comb begin
        w_acc_ext = {i_acc[ACC_W-1], i_acc};
`ifdef NEURON_MAC_ROUND_EN
        w_biased  = w_acc_ext + $signed({{(ACC_W+1-FRAC_BITS){1'b0}}, 1'b1,
                                         {(FRAC_BITS-1){1'b0}}});
`else
        w_biased  = w_acc_ext;
`endif
        w_scaled  = w_biased >>> FRAC_BITS;
    end

    // Clamp the scaled value into the representable Q1.6 range
    always_comb begin
        o_q = w_scaled[DATA_W-1:0];
        if (w_scaled > w_max) begin
            o_q = Q_MAX;
        end else if (w_scaled < w_min) begin
            o_q = Q_MIN;
        end else begin
            o_q = w_scaled[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// Multiply-accumulate stage for one NAR-Net neuron. Streams N_IN signed
// Q1.6 x/w pairs, adds a Q1.6 bias, and registers the rescaled, saturated
// sum as the tanh_lut address. addr only moves when addr_valid pulses, so
// the LUT's falling-edge read always sees a settled value.
// Build option: NEURON_MAC_ROUND_EN (round-half-up in q_round_sat).
module neuron_mac
    import nar_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int ACC_W = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] bias,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] x_in,
    input  logic [7:0] w_in,
    output logic [7:0] addr,
    output logic       addr_valid,
    output logic       busy
);

    // Counter must be able to hold N_IN itself (up to 16)
    localparam int               CNT_W    = $clog2(N_IN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_IN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mac_state_t         r_state;
    mac_state_t         w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_addr;
    logic               r_addr_valid;
    logic               r_in_ready;
    logic               r_busy;

    logic               w_load;
    logic               w_beat;
    logic               w_last;
    logic               w_finish;
    logic signed [15:0] w_prod;
    logic [ACC_W-1:0]   w_prod_ext;
    logic [ACC_W-1:0]   w_bias_ext;
    logic [DATA_W-1:0]  w_q;

    // Q1.6 x Q1.6 -> Q2.12; -128 x -128 = +16384 still fits in 16 bits signed
    assign w_prod     = $signed(x_in) * $signed(w_in);
    assign w_prod_ext = {{(ACC_W-16){w_prod[15]}}, w_prod};

    // Bias moved to Q*.12 alignment so it adds directly to the products
    assign w_bias_ext = {{(ACC_W-DATA_W-FRAC_BITS){bias[DATA_W-1]}}, bias,
                         {FRAC_BITS{1'b0}}};

    // A beat transfers only while ready is presented (ACCUM state)
    assign w_beat = in_valid && r_in_ready;
    assign w_last = w_beat && (r_cnt == LAST_CNT);

    q_round_sat #(
        .ACC_W (ACC_W)
    ) u_round_sat (
        .i_acc (r_acc),
        .o_q   (w_q)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and datapath control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ACCUM;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACCUM: begin
                if (w_last) begin
                    w_state_nxt = FINISH;
                end else begin
                    w_state_nxt = ACCUM;
                end
            end
            FINISH: begin
                w_finish    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Accumulator and beat counter: load on start, add on each beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_acc <= w_bias_ext;
            r_cnt <= '0;
        end else if (w_beat) begin
            r_acc <= r_acc + w_prod_ext;
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_acc <= r_acc;
            r_cnt <= r_cnt;
        end
    end

    // Result register: addr updates only on the FINISH edge, valid pulses once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_addr_valid <= 1'b0;
        end else if (w_finish) begin
            r_addr       <= w_q;
            r_addr_valid <= 1'b1;
        end else begin
            r_addr       <= r_addr;
            r_addr_valid <= 1'b0;
        end
    end

    // Handshake/status flags registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_in_ready <= (w_state_nxt == ACCUM);
            r_busy     <= (w_state_nxt != IDLE);
        end
    end

    assign in_ready   = r_in_ready;
    assign busy       = r_busy;
    assign addr       = r_addr;
    assign addr_valid = r_addr_valid;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed self-checking bench for neuron_mac (N_IN=4). Expected values are
// hand-computed Q1.6 results; rounding expectations follow NEURON_MAC_ROUND_EN.
module tb_neuron_mac;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] bias;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x_in;
    logic [7:0] w_in;
    logic [7:0] addr;
    logic       addr_valid;
    logic       busy;

    int n_tests;
    int n_fail;

`ifdef NEURON_MAC_ROUND_EN
    localparam logic [7:0] EXP_ROUND  = 8'h01;
    localparam logic [7:0] EXP_NEGONE = 8'h00;
`else
    localparam logic [7:0] EXP_ROUND  = 8'h00;
    localparam logic [7:0] EXP_NEGONE = 8'hFF;
`endif

    neuron_mac #(
        .N_IN  (4),
        .ACC_W (24)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bias       (bias),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x_in       (x_in),
        .w_in       (w_in),
        .addr       (addr),
        .addr_valid (addr_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One result: start (with a same-cycle in_valid that must be ignored),
    // four beats, optional gap before beat 3 with optional start pulse.
    task automatic run_mac(input logic [7:0] b, input logic [31:0] xv,
                           input logic [31:0] wv, input int gap,
                           input logic pulse_start, input logic [7:0] exp_addr,
                           input string tag);
        int cyc;
        bit seen;
        start    = 1'b1;
        bias     = b;
        in_valid = 1'b1;
        x_in     = 8'h7F;
        w_in     = 8'h7F;
        tick();
        start    = 1'b0;
        bias     = 8'h55;
        in_valid = 1'b0;
        cyc      = 0;
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check_eq({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i == 2 && gap > 0) begin
                in_valid = 1'b0;
                start    = pulse_start;
                repeat (gap) begin
                    tick();
                    cyc++;
                end
                start = 1'b0;
            end
            in_valid = 1'b1;
            x_in     = xv[8*i +: 8];
            w_in     = wv[8*i +: 8];
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check_eq({tag, "_fin_rdy"}, {31'd0, in_ready}, 32'd0);
        check_eq({tag, "_fin_vld"}, {31'd0, addr_valid}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            cyc++;
            if (addr_valid) seen = 1'b1;
        end
        check_eq({tag, "_seen"}, {31'd0, seen}, 32'd1);
        check_eq({tag, "_lat"}, cyc, 32'(5 + gap));
        check_eq({tag, "_addr"}, {24'd0, addr}, {24'd0, exp_addr});
    endtask

    // Cycle after a result: pulse gone, idle, addr held
    task automatic after_result(input logic [7:0] exp_addr, input string tag);
        tick();
        check_eq({tag, "_vld_drop"}, {31'd0, addr_valid}, 32'd0);
        check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_hold"}, {24'd0, addr}, {24'd0, exp_addr});
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        bias     = 8'h00;
        in_valid = 1'b0;
        x_in     = 8'h00;
        w_in     = 8'h00;
        #3;
        check_eq("rst_addr", {24'd0, addr}, 32'd0);
        check_eq("rst_vld", {31'd0, addr_valid}, 32'd0);
        check_eq("rst_rdy", {31'd0, in_ready}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_mac(8'h10, 32'h40404040, 32'h10101010, 0, 1'b0, 8'h50, "basic");
        after_result(8'h50, "basic");
        run_mac(8'h7F, 32'h7F7F7F7F, 32'h7F7F7F7F, 0, 1'b0, 8'h7F, "possat");
        after_result(8'h7F, "possat");
        run_mac(8'h00, 32'h80808080, 32'h7F7F7F7F, 0, 1'b0, 8'h80, "negsat");
        after_result(8'h80, "negsat");
        run_mac(8'h00, 32'h00000001, 32'h00000020, 0, 1'b0, EXP_ROUND, "round");
        after_result(EXP_ROUND, "round");
        run_mac(8'h00, 32'h000000FF, 32'h00000001, 0, 1'b0, EXP_NEGONE, "negone");
        after_result(EXP_NEGONE, "negone");
        run_mac(8'h00, 32'h00000080, 32'h00000080, 0, 1'b0, 8'h7F, "minmin");
        after_result(8'h7F, "minmin");

        // Back-to-back: second start issued in the IDLE cycle carrying addr_valid
        run_mac(8'hC0, 32'h40404040, 32'h20202020, 0, 1'b0, 8'h40, "negbias");
        run_mac(8'h10, 32'h40404040, 32'h10101010, 0, 1'b0, 8'h50, "b2b");
        after_result(8'h50, "b2b");

        // Backpressure gap with start pulsed during ACCUM
        run_mac(8'h10, 32'h40404040, 32'h10101010, 3, 1'b1, 8'h50, "bp");
        after_result(8'h50, "bp");
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("bp_no_restart", {31'd0, busy}, 32'd0);
            check_eq("bp_single_pulse", {31'd0, addr_valid}, 32'd0);
        end

        // Reset in the middle of accumulation
        start = 1'b1;
        bias  = 8'h10;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        x_in     = 8'h40;
        w_in     = 8'h10;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_addr", {24'd0, addr}, 32'd0);
        check_eq("mid_rst_vld", {31'd0, addr_valid}, 32'd0);
        check_eq("mid_rst_rdy", {31'd0, in_ready}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        run_mac(8'h10, 32'h40404040, 32'h10101010, 0, 1'b0, 8'h50, "post_rst");
        after_result(8'h50, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
